// File: rtl/nios2_oci_dct_packer_if.sv
// rtl/nios2_oci_dct_packer_if.sv - symbol/packet handshake bundle for the DCT packer
//
// Purpose: groups the trace-symbol input, the packet output and the drop
// status of nios2_oci_dct_packer into one bundle.
// Signals:
//   sym_valid/sym_data/sym_ready  trace symbol handshake (source -> packer)
//   flush                         close the current partial packet
//   out_valid/out_ready           packet handshake (packer -> OCI monitor)
//   dct_buffer/dct_count          packed symbols and number of valid symbols
//   overflow/drop_count           sticky lost-symbol status
// Modports: slave = packer side, master = trace source / consumer side.

interface nios2_oci_dct_packer_if #(
  parameter int SYM_W    = 2,
  parameter int NUM_SYMS = 15,
  parameter int CNT_W    = 4
);

  logic                      sym_valid;
  logic [SYM_W-1:0]          sym_data;
  logic                      sym_ready;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [SYM_W*NUM_SYMS-1:0] dct_buffer;
  logic [CNT_W-1:0]          dct_count;
  logic                      overflow;
  logic [7:0]                drop_count;

  modport slave (
    input  sym_valid, sym_data, flush, out_ready,
    output sym_ready, out_valid, dct_buffer, dct_count, overflow, drop_count
  );

  modport master (
    output sym_valid, sym_data, flush, out_ready,
    input  sym_ready, out_valid, dct_buffer, dct_count, overflow, drop_count
  );

endinterface

// File: rtl/nios2_oci_dct_packer.sv
// rtl/nios2_oci_dct_packer.sv - DCT trace packer feeding the OCI monitor dct_buffer/dct_count
//
// Purpose: packs up to NUM_SYMS trace symbols of SYM_W bits into one word,
// oldest symbol in the most significant occupied slot, and hands each full
// or flushed word downstream over a valid/ready handshake.
// Ports:
//   clk      single clock, all state on the rising edge
//   reset_n  asynchronous active-low reset
//   bus      nios2_oci_dct_packer_if.slave (symbol in, packet out, drop status)

module nios2_oci_dct_packer #(
  parameter int SYM_W    = 2,
  parameter int NUM_SYMS = 15,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nios2_oci_dct_packer_if.slave bus
);

  localparam int               BUF_W    = SYM_W * NUM_SYMS;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SYMS);
  localparam logic [7:0]       DROP_MAX = 8'hFF;

  // FILL accepts symbols; CLOSE holds a finished packet in the accumulator
  // until the output register is free to take it.
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_CLOSE = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [BUF_W-1:0] acc;
  logic [CNT_W-1:0] acc_cnt;
  logic             flush_pend;

  logic             out_valid_q;
  logic [BUF_W-1:0] dct_buffer_q;
  logic [CNT_W-1:0] dct_count_q;
  logic             overflow_q;
  logic [7:0]       drop_count_q;

  logic             accept;
  logic [CNT_W-1:0] cnt_after;
  logic             sym_ready_c;
  logic             close_now;
  logic             xfer;

  // Acceptance is derived from the state directly (not from sym_ready_c) so
  // the close decision below does not loop back through the output process.
  assign accept    = bus.sym_valid && (state == ST_FILL);
  assign cnt_after = acc_cnt + CNT_W'(accept);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: begin
        if (close_now) begin
          state_nxt = ST_CLOSE;
        end
      end
      ST_CLOSE: begin
        if (xfer) begin
          state_nxt = ST_FILL;
        end
      end
      default: begin
        state_nxt = ST_FILL;
      end
    endcase
  end

  // Output / control decode
  always_comb begin
    sym_ready_c = 1'b0;
    close_now   = 1'b0;
    xfer        = 1'b0;
    case (state)
      ST_FILL: begin
        sym_ready_c = 1'b1;
        // A symbol taken in the same cycle as the flush counts toward the
        // packet; a flush with nothing buffered is simply ignored.
        close_now   = (cnt_after == FULL_CNT) ||
                      ((bus.flush || flush_pend) && (cnt_after != '0));
      end
      ST_CLOSE: begin
        // The output register is free when empty or being drained this cycle,
        // which lets packets go out back to back.
        xfer = !out_valid_q || bus.out_ready;
      end
      default: begin
        sym_ready_c = 1'b0;
      end
    endcase
  end

  // Accumulator: new symbols shift in at the bottom, so unused upper slots
  // of a partial packet stay zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (xfer) begin
      acc     <= '0;
      acc_cnt <= '0;
    end else if (accept) begin
      acc     <= {acc[BUF_W-SYM_W-1:0], bus.sym_data};
      acc_cnt <= cnt_after;
    end
  end

  // A flush that arrives while a packet is waiting cannot act on the buffer
  // yet; remember it and apply it to the next non-empty packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush_pend <= 1'b0;
    end else if ((state == ST_CLOSE) && bus.flush) begin
      flush_pend <= 1'b1;
    end else if (close_now) begin
      flush_pend <= 1'b0;
    end
  end

  // Output register: holds its contents while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      dct_buffer_q <= '0;
      dct_count_q  <= '0;
    end else if (xfer) begin
      out_valid_q  <= 1'b1;
      dct_buffer_q <= acc;
      dct_count_q  <= acc_cnt;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  // Lost-symbol status; sticky until reset, counter saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else if (bus.sym_valid && !sym_ready_c) begin
      overflow_q <= 1'b1;
      if (drop_count_q != DROP_MAX) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign bus.sym_ready  = sym_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.dct_buffer = dct_buffer_q;
  assign bus.dct_count  = dct_count_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_count = drop_count_q;

endmodule

// File: tb/tb_nios2_oci_dct_packer.sv
// tb/tb_nios2_oci_dct_packer.sv - self-checking bench for nios2_oci_dct_packer

module tb_nios2_oci_dct_packer;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  nios2_oci_dct_packer_if bus ();

  nios2_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic        rdy_drv;
  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  logic [1:0]  cur_q[$];
  bit          pend;
  int          model_drops;
  int          hold_err;
  bit          hold_active;
  logic [29:0] hold_buf;
  logic [3:0]  hold_cnt;

  // Reference packet: symbol i of n sits at bit position 2*(n-1-i).
  function automatic logic [33:0] pack_cur();
    logic [29:0] v;
    int n;
    v = '0;
    n = cur_q.size();
    for (int i = 0; i < n; i++) v = v + (30'(cur_q[i]) << (2 * (n - 1 - i)));
    return {4'(n), v};
  endfunction

  function automatic void model_update(bit took, logic [1:0] s, bit f, bit ready);
    if (!ready) begin
      if (f) pend = 1'b1;
      return;
    end
    if (took) cur_q.push_back(s);
    if (cur_q.size() == 15 || ((f || pend) && cur_q.size() >= 1)) begin
      exp_q.push_back(pack_cur());
      cur_q.delete();
      pend = 1'b0;
    end
  endfunction

  function automatic void clear_model();
    exp_q.delete();
    got_q.delete();
    cur_q.delete();
    pend        = 1'b0;
    model_drops = 0;
    hold_err    = 0;
    hold_active = 1'b0;
  endfunction

  // One clock cycle: drive inputs at the falling edge, observe outputs,
  // record delivered packets and advance the reference model.
  task automatic step(input bit v, input logic [1:0] s, input bit f, input bit gate, output bit took);
    bit ready;
    @(negedge clk);
    ready         = bus.sym_ready;
    bus.sym_valid = v && (!gate || ready);
    bus.sym_data  = s;
    bus.flush     = f;
    bus.out_ready = rdy_drv;
    took          = bus.sym_valid && ready;
    if (bus.sym_valid && !ready) model_drops++;
    if (hold_active && (bus.out_valid !== 1'b1 || bus.dct_buffer !== hold_buf || bus.dct_count !== hold_cnt))
      hold_err++;
    hold_active = (bus.out_valid === 1'b1) && !rdy_drv;
    hold_buf    = bus.dct_buffer;
    hold_cnt    = bus.dct_count;
    if (bus.out_valid === 1'b1 && rdy_drv) got_q.push_back({bus.dct_count, bus.dct_buffer});
    model_update(took, s, f, ready);
  endtask

  task automatic idle(input int n);
    bit t;
    repeat (n) step(1'b0, 2'd0, 1'b0, 1'b0, t);
  endtask

  task automatic send(input logic [1:0] s);
    bit took;
    took = 1'b0;
    for (int i = 0; i < 40 && !took; i++) step(1'b1, s, 1'b0, 1'b1, took);
    checks++;
    if (!took) begin
      failures++;
      $display("FAIL send_timeout: symbol %0d not accepted, required acceptance within 40 cycles", s);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n       = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_data  = 2'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_model();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.dct_buffer !== 30'h0) begin failures++; $display("FAIL reset_dct_buffer: got %h required 0", bus.dct_buffer); end
    checks++; if (bus.dct_count !== 4'h0) begin failures++; $display("FAIL reset_dct_count: got %0d required 0", bus.dct_count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b required 0", bus.overflow); end
    checks++; if (bus.drop_count !== 8'h0) begin failures++; $display("FAIL reset_drop_count: got %0d required 0", bus.drop_count); end
    reset_n = 1'b1;
    clear_model();
    idle(1);
    checks++; if (bus.sym_ready !== 1'b1) begin failures++; $display("FAIL reset_sym_ready: got %b required 1", bus.sym_ready); end
  endtask

  task automatic test_full_packet();
    bit t;
    rdy_drv = 1'b1;
    clear_model();
    for (int i = 0; i < 15; i++) step(1'b1, 2'(i % 4), 1'b0, 1'b0, t);
    step(1'b0, 2'd0, 1'b0, 1'b0, t);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_n1_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.sym_ready !== 1'b0) begin failures++; $display("FAIL full_n1_ready: got %b required 0", bus.sym_ready); end
    step(1'b0, 2'd0, 1'b0, 1'b0, t);
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL full_n2_valid: got %b required 1", bus.out_valid); end
    checks++; if (bus.dct_count !== 4'd15) begin failures++; $display("FAIL full_count: got %0d required 15", bus.dct_count); end
    checks++; if (bus.dct_buffer !== 30'h06C6C6C6) begin failures++; $display("FAIL full_buffer: got %h required 06c6c6c6", bus.dct_buffer); end
    step(1'b0, 2'd0, 1'b0, 1'b0, t);
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL full_n3_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL full_overflow: got %b required 0", bus.overflow); end
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL full_pkt_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL full_pkt_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_flush_partial();
    bit t;
    bit seen;
    rdy_drv = 1'b1;
    clear_model();
    step(1'b1, 2'd3, 1'b0, 1'b0, t);
    step(1'b1, 2'd2, 1'b0, 1'b0, t);
    step(1'b1, 2'd1, 1'b0, 1'b0, t);
    step(1'b0, 2'd0, 1'b1, 1'b0, t);
    idle(4);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL flush_pkt_count: got %0d required 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== {4'd3, 30'h39}) begin failures++; $display("FAIL flush_pkt: got %h required %h", got_q[0], {4'd3, 30'h39}); end
    end
    seen = 1'b0;
    step(1'b0, 2'd0, 1'b1, 1'b0, t);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 1'b0, 1'b0, t);
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin failures++; $display("FAIL flush_empty: got out_valid=1 required no packet"); end
  endtask

  task automatic test_flush_with_symbol();
    bit t;
    rdy_drv = 1'b1;
    clear_model();
    step(1'b1, 2'd2, 1'b1, 1'b0, t);
    idle(4);
    checks++; if (got_q.size() != 1) begin failures++; $display("FAIL flush_sym_count: got %0d required 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      checks++; if (got_q[0] !== {4'd1, 30'h2}) begin failures++; $display("FAIL flush_sym_pkt: got %h required %h", got_q[0], {4'd1, 30'h2}); end
    end
  endtask

  task automatic test_backpressure();
    bit t;
    rdy_drv = 1'b0;
    clear_model();
    for (int i = 0; i < 30; i++) send(2'($urandom));
    step(1'b1, 2'($urandom), 1'b0, 1'b0, t);
    idle(3);
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL bp_overflow: got %b required 1", bus.overflow); end
    checks++; if (bus.drop_count !== 8'd1) begin failures++; $display("FAIL bp_drop_count: got %0d required 1", bus.drop_count); end
    checks++; if (bus.sym_ready !== 1'b0) begin failures++; $display("FAIL bp_sym_ready: got %b required 0", bus.sym_ready); end
    checks++; if (exp_q.size() != 2) begin failures++; $display("FAIL bp_model_pkts: got %0d required 2", exp_q.size()); end
    if (exp_q.size() >= 1) begin
      checks++; if ({bus.dct_count, bus.dct_buffer} !== exp_q[0]) begin failures++; $display("FAIL bp_held_pkt: got %h required %h", {bus.dct_count, bus.dct_buffer}, exp_q[0]); end
    end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles required 0", hold_err); end
    rdy_drv = 1'b1;
    idle(8);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_pkt_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_pkt_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_packet();
    bit t;
    rdy_drv = 1'b0;
    clear_model();
    for (int i = 0; i < 20; i++) send(2'($urandom));
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid: got %b required 0", bus.out_valid); end
    checks++; if (bus.dct_buffer !== 30'h0) begin failures++; $display("FAIL rst_mid_buffer: got %h required 0", bus.dct_buffer); end
    checks++; if (bus.dct_count !== 4'h0) begin failures++; $display("FAIL rst_mid_count: got %0d required 0", bus.dct_count); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rst_mid_overflow: got %b required 0", bus.overflow); end
    checks++; if (bus.drop_count !== 8'h0) begin failures++; $display("FAIL rst_mid_drops: got %0d required 0", bus.drop_count); end
    bus.sym_valid = 1'b0;
    bus.flush     = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    clear_model();
    rdy_drv = 1'b1;
    idle(6);
    checks++; if (got_q.size() != 0) begin failures++; $display("FAIL rst_mid_leak: got %0d packets required 0", got_q.size()); end
    for (int i = 0; i < 15; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0, t);
    idle(4);
    checks++; if (got_q.size() != 1 || exp_q.size() != 1) begin failures++; $display("FAIL rst_mid_pkt_count: got %0d required 1 (model %0d)", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_mid_pkt_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_drop_saturate();
    bit t;
    rdy_drv = 1'b0;
    clear_model();
    for (int i = 0; i < 300; i++) step(1'b1, 2'($urandom), 1'b0, 1'b0, t);
    idle(1);
    checks++; if (bus.drop_count !== 8'd255) begin failures++; $display("FAIL sat_drop_count: got %0d required 255", bus.drop_count); end
    checks++; if (bus.drop_count !== 8'((model_drops > 255) ? 255 : model_drops)) begin failures++; $display("FAIL sat_drop_model: got %0d required %0d", bus.drop_count, (model_drops > 255) ? 255 : model_drops); end
    checks++; if (bus.overflow !== 1'b1) begin failures++; $display("FAIL sat_overflow: got %b required 1", bus.overflow); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL sat_hold: got %0d unstable cycles required 0", hold_err); end
    rdy_drv = 1'b1;
    idle(8);
    checks++; if (got_q.size() != 2 || exp_q.size() != 2) begin failures++; $display("FAIL sat_pkt_count: got %0d required 2 (model %0d)", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL sat_pkt_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    bit t;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rdy_drv = ($urandom_range(0, 3) != 0);
      step($urandom_range(0, 1) == 1, 2'($urandom), $urandom_range(0, 9) == 0, 1'b1, t);
    end
    rdy_drv = 1'b1;
    step(1'b0, 2'd0, 1'b1, 1'b0, t);
    idle(6);
    step(1'b0, 2'd0, 1'b1, 1'b0, t);
    idle(6);
    checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rnd_pkt_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_pkt_%0d: got %h required %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL rnd_hold: got %0d unstable cycles required 0", hold_err); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL rnd_overflow: got %b required 0", bus.overflow); end
    checks++; if (bus.drop_count !== 8'd0) begin failures++; $display("FAIL rnd_drop_count: got %0d required 0", bus.drop_count); end
  endtask

  initial begin
    rdy_drv       = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_data  = 2'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    clear_model();
    test_reset();
    test_full_packet();
    test_flush_partial();
    test_flush_with_symbol();
    test_backpressure();
    test_reset_mid_packet();
    test_drop_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded 500000 required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/nios2_oci_dct_packer.md
Name: nios2_oci_dct_packer

Overview:
- Data-compression trace (DCT) packer; sits directly upstream of the OCI test-bench monitor and drives its dct_buffer / dct_count inputs.
- Accepts 2-bit trace symbols from the OCI trace source and packs up to 15 of them into a 30-bit word.
- Hands each completed or flushed word downstream over a valid/ready handshake, and records lost symbols in sticky status.

Parameters:
- SYM_W, 2, width of one trace symbol in bits.
- NUM_SYMS, 15, symbols per full packet; buffer width is SYM_W*NUM_SYMS = 30.
- CNT_W, 4, width of dct_count; must satisfy 2**CNT_W > NUM_SYMS.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sym_valid  in  1  a trace symbol is presented this cycle.
- sym_data  in  SYM_W  trace symbol.
- sym_ready  out  1  packer can accept a symbol this cycle.
- flush  in  1  single-cycle request to close the current partial packet.
- out_valid  out  1  dct_buffer / dct_count hold a packet.
- out_ready  in  1  consumer accepts the packet this cycle.
- dct_buffer  out  30  packed symbols; oldest symbol in the most significant occupied slot.
- dct_count  out  CNT_W  number of valid symbols in dct_buffer (1..15 while out_valid=1).
- overflow  out  1  sticky: a symbol was presented while sym_ready=0.
- drop_count  out  8  number of dropped symbols; saturates at 255.

Behaviour:
- Reset (asynchronous assert, synchronous release): accumulator acc=0, acc_cnt=0, flush_pend=0, out_valid=0, dct_buffer=0, dct_count=0, overflow=0, drop_count=0, state=FILL.
- Symbol accept: a symbol is accepted when sym_valid & sym_ready.
  - acc <= {acc[27:0], sym_data}; acc_cnt += 1.
  - In a partial packet, occupied bits are [2*cnt-1:0] and the upper bits are 0.
- States:
  - FILL: sym_ready=1. Go to CLOSE when acc_cnt reaches 15, or when a flush (flush or flush_pend) is seen with a post-accept count >= 1.
  - CLOSE: sym_ready=0. The accumulator waits for the output register. Return to FILL after the transfer.
- Flush rules:
  - A symbol accepted in the same cycle as flush is included in the packet.
  - Flush with count 0 and no symbol that cycle is ignored; no packet is produced.
  - A flush arriving while in CLOSE sets flush_pend. flush_pend is consumed by the next packet that closes, as long as that packet has count >= 1.
- Transfer: from CLOSE, when out_valid=0 or (out_valid & out_ready):
  - Move acc/acc_cnt into dct_buffer/dct_count and set out_valid=1.
  - Clear acc and acc_cnt, and return to FILL.
  - Latency: a packet closed in cycle N with a free output register shows out_valid=1 in cycle N+2. The close register takes N+1, the transfer takes N+2.
- Output hold: dct_buffer/dct_count must stay stable while out_valid & !out_ready.
  - out_valid falls after a handshake unless a new transfer happens in the same cycle (back-to-back packets).
- Drops: sym_valid & !sym_ready sets overflow=1 and increments drop_count, saturating at 255. Both clear only on reset.
- Reset mid-packet: any partial accumulator or pending output is discarded and nothing is emitted.

Test Plan:
- 15 symbols 0,1,2,3,0,1,2,3,... on consecutive cycles with out_ready=1 -> one packet: dct_count=15, dct_buffer=0x06C6C6C6 (symbol 0 in bits [29:28]), out_valid high for 1 cycle, overflow=0.
- 3 symbols 3,2,1, then flush -> dct_count=3, dct_buffer=0x00000039. Flush with count 0 -> no out_valid.
- Symbol 2 together with flush on an empty packer -> dct_count=1, dct_buffer=0x2.
- out_ready=0 and 31 symbols -> first packet held stable, second packet waits in CLOSE, 31st symbol dropped. Result: overflow=1, drop_count=1. Then out_ready=1 -> both 15-symbol packets emitted in order.
- 20 symbols then reset_n low mid-stream -> all outputs 0 immediately, no packet after release. The next 15 symbols produce a clean packet.
- With out_ready held low, drive 300 symbols -> drop_count saturates at 255.
